// File: rtl/pointer_register.sv
// pointer_register: read-address sequencer for the binary-code-modulation
// display path. Scans every pixel of a bit-plane, repeats that scan
// 2^plane times, then moves to the next plane, wrapping after the last one.
module pointer_register #(
  parameter int PLANE_W = 3,
  parameter int INDEX_W = 5,
  parameter int ADDR_W  = PLANE_W + INDEX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] address
);

  // Pass counter is wide enough to hold 2^(top plane) - 1.
  localparam int REP_W = (2 ** PLANE_W) - 1;

  localparam logic [INDEX_W-1:0] INDEX_MAX = '1;
  localparam logic [PLANE_W-1:0] PLANE_MAX = '1;
  localparam logic [REP_W:0]     REP_ONE   = {{REP_W{1'b0}}, 1'b1};

  logic [PLANE_W-1:0] plane;
  logic [INDEX_W-1:0] index;
  logic [REP_W-1:0]   rep;

  logic [PLANE_W-1:0] planeNext;
  logic [INDEX_W-1:0] indexNext;
  logic [REP_W-1:0]   repNext;

  // One bit wider than rep so the shift for the top plane is not truncated.
  logic [REP_W:0]     repLimit;
  logic               lastPixel;
  logic               lastPass;
  logic               lastPlane;

  // Decode where we are in the scan: end of row, final pass of plane, top plane.
  always_comb begin
    repLimit  = (REP_ONE << plane) - REP_ONE;
    lastPixel = (index == INDEX_MAX);
    lastPass  = ({1'b0, rep} == repLimit);
    lastPlane = (plane == PLANE_MAX);
  end

  // Step the pointer: advance pixel, else repeat scan, else next plane, else wrap.
  always_comb begin
    planeNext = plane;
    indexNext = index;
    repNext   = rep;
    if (!lastPixel) begin
      indexNext = index + 1'b1;
    end else if (!lastPass) begin
      indexNext = '0;
      repNext   = rep + 1'b1;
    end else if (!lastPlane) begin
      indexNext = '0;
      repNext   = '0;
      planeNext = plane + 1'b1;
    end else begin
      indexNext = '0;
      repNext   = '0;
      planeNext = '0;
    end
  end

  // Sequencer state; reset restarts the frame from the first pixel of plane 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plane <= '0;
      index <= '0;
      rep   <= '0;
    end else begin
      plane <= planeNext;
      index <= indexNext;
      rep   <= repNext;
    end
  end

  // Address comes straight from the registers, so it is glitch-free.
  assign address = {plane, index};

endmodule

// File: tb/tb_pointer_register.sv
// tb_pointer_register: randomized run lengths and reset placements, with
// every post-edge address compared to a frame-position reference model.
module tb_pointer_register;

  localparam int FRAME = 32 * 255;

  logic       clk;
  logic       rst_n;
  logic [7:0] address;

  int total;
  int bad;
  int edges;
  int scans [8];

  pointer_register dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .address (address)
  );

  // 20 ns system clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference: position n within the frame, walking the weighted plane spans.
  function automatic logic [7:0] modelAddr(input int n);
    int m;
    int k;
    int base;
    m    = n % FRAME;
    k    = 0;
    base = 0;
    while (m >= base + 32 * (1 << k)) begin
      base = base + 32 * (1 << k);
      k    = k + 1;
    end
    return 8'(k * 32 + ((m - base) % 32));
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total = total + 1;
    if (observed !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s edge=%0d observed=%h expected=%h", tag, edges,
               observed, expected);
    end
  endtask

  // Clock n edges, checking every step against the model and the key table.
  task automatic runEdges(input int n);
    repeat (n) begin
      @(posedge clk);
      edges = edges + 1;
      #1;
      checkOutput("seq", address, modelAddr(edges));
      if (edges < FRAME && address[4:0] == 5'd31)
        scans[address[7:5]] = scans[address[7:5]] + 1;
      case (edges)
        1:    checkOutput("key1",    address, 8'h01);
        31:   checkOutput("key31",   address, 8'h1F);
        32:   checkOutput("key32",   address, 8'h20);
        63:   checkOutput("key63",   address, 8'h3F);
        64:   checkOutput("key64",   address, 8'h20);
        96:   checkOutput("key96",   address, 8'h40);
        224:  checkOutput("key224",  address, 8'h60);
        300:  checkOutput("key300",  address, 8'h6C);
        4064: checkOutput("key4064", address, 8'hE0);
        4128: checkOutput("key4128", address, 8'hE0);
        8159: checkOutput("key8159", address, 8'hFF);
        8160: checkOutput("key8160", address, 8'h00);
        8161: checkOutput("key8161", address, 8'h01);
        default: ;
      endcase
    end
  endtask

  // Hold reset low for n clock cycles, confirming the pointer stays parked.
  task automatic holdReset(input int n);
    repeat (n) begin
      @(negedge clk);
      checkOutput("held", address, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
  endtask

  // Random-length run, then an asynchronous reset dropped between edges.
  task automatic applyStimulus(input int runLen, input int holdLen);
    runEdges(runLen);
    #($urandom_range(2, 7));
    rst_n = 1'b0;
    #1;
    checkOutput("async", address, 8'h00);
    holdReset(holdLen);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    edges = 0;
    foreach (scans[i]) scans[i] = 0;
    rst_n = 1'b0;

    #5;
    checkOutput("reset0", address, 8'h00);
    holdReset(4);

    // Full frame plus one step, with scan counting per plane.
    runEdges(FRAME + 1);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("scans%0d", k), 8'(scans[k]), 8'(1 << k));

    // Mid-frame aborts at random points with random reset lengths.
    #($urandom_range(2, 7));
    rst_n = 1'b0;
    #1;
    checkOutput("async0", address, 8'h00);
    holdReset(3);
    for (int t = 0; t < 6; t++)
      applyStimulus($urandom_range(1, 2500), $urandom_range(1, 6));

    // 6000 ns high / 6000 ns low style: 300 edges, 300-cycle reset, restart.
    applyStimulus(300, 299);
    runEdges(320);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
